mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port between the multi-cycle
// core (port C) and the debug/program-loader port (port D).
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   core_*             core request/write/address/data in; grant, stall, read data out
//   dbg_*              debug request/write/lock/address/data in; grant, read data out
//   mem_*              muxed address/write data/write enable out, combinational read data in
//   core_xfer_cnt,
//   dbg_xfer_cnt       completed-transfer counters (zero unless MEM_ARB_PERF_EN is defined)
//
// Optional build macro: MEM_ARB_PERF_EN enables the two 32-bit transfer counters.
module mem_port_arbiter #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned WAIT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [BIT_WIDTH-1:0] core_addr,
  input  logic [BIT_WIDTH-1:0] core_wdata,
  output logic                 core_gnt,
  output logic                 core_stall,
  output logic [BIT_WIDTH-1:0] core_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic                 dbg_lock,
  input  logic [BIT_WIDTH-1:0] dbg_addr,
  input  logic [BIT_WIDTH-1:0] dbg_wdata,
  output logic                 dbg_gnt,
  output logic [BIT_WIDTH-1:0] dbg_rdata,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  output logic [31:0]          core_xfer_cnt,
  output logic [31:0]          dbg_xfer_cnt
);

  typedef enum logic [1:0] {OwnNone, OwnCore, OwnDbg} owner_e;

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  owner_e            owner_q, owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              core_xfer, dbg_xfer, dbg_starved;

  assign core_xfer   = core_req & (owner_q == OwnCore);
  assign dbg_xfer    = dbg_req & (owner_q == OwnDbg);
  assign dbg_starved = (wait_cnt_q == MaxWait);

  // Starvation override is suppressed while D is being served this cycle: the
  // saturated count belongs to the wait just ended, so an unlocked single access
  // hands the port straight back to the core.
  always_comb begin
    owner_d = OwnNone;
    if ((owner_q == OwnDbg) && dbg_req && dbg_lock) begin
      owner_d = OwnDbg;
    end else if (dbg_req && !dbg_xfer && dbg_starved) begin
      owner_d = OwnDbg;
    end else if (core_req) begin
      owner_d = OwnCore;
    end else if (dbg_req) begin
      owner_d = OwnDbg;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req || dbg_xfer) begin
      wait_cnt_d = '0;
    end else if (!dbg_starved) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OwnNone;
      wait_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign core_gnt   = (owner_q == OwnCore);
  assign dbg_gnt    = (owner_q == OwnDbg);
  assign core_stall = core_req & ~core_gnt;

  assign mem_addr  = (owner_q == OwnDbg) ? dbg_addr : core_addr;
  assign mem_wdata = (owner_q == OwnDbg) ? dbg_wdata : core_wdata;
  // Reset aborts an in-flight write; a dropped request under a stale grant writes nothing.
  assign mem_we    = ~rst & ((core_xfer & core_we) | (dbg_xfer & dbg_we));

  assign core_rdata = mem_rdata;
  assign dbg_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] core_cnt_q, dbg_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_cnt_q <= '0;
      dbg_cnt_q  <= '0;
    end else begin
      if (core_xfer) core_cnt_q <= core_cnt_q + 32'd1;
      if (dbg_xfer)  dbg_cnt_q  <= dbg_cnt_q + 32'd1;
    end
  end

  assign core_xfer_cnt = core_cnt_q;
  assign dbg_xfer_cnt  = dbg_cnt_q;
`else
  assign core_xfer_cnt = '0;
  assign dbg_xfer_cnt  = '0;
`endif

endmodule
